// File: rtl/bundle_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bundle_arb_pkg
//
// Shared definitions for the bundle_arbiter codebase slice:
//   arb_state_e  : two-state ownership FSM encoding (IDLE, OWN)
//   VEC_RESET    : all-ones reset pattern for the shared vector; the top
//                  level slices it down to its own WIDTH (WIDTH <= 64)
//   safe_clog2   : clog2-derived width helper that never returns zero, so a
//                  degenerate parameter still yields a legal 1-bit field
// ---------------------------------------------------------------------------
package bundle_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int MAX_VEC_W = 64;

    localparam logic [MAX_VEC_W-1:0] VEC_RESET = '1;

    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bundle_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker. Scans the request vector starting at the
// pointer position and wrapping modulo NUM_REQ; the first set bit wins.
//
// Ports:
//   i_req    in   NUM_REQ  request vector
//   i_ptr    in   PTR_W    scan start position (always < NUM_REQ)
//   o_valid  out  1        at least one request is set
//   o_winner out  PTR_W    index of the winning requester (0 when none)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [PTR_W-1:0]   o_winner
);

    // Walk the offsets from the farthest back to the nearest, so the
    // candidate closest to the pointer is the last one written and therefore
    // wins. The sum ptr+offset stays below 2*NUM_REQ, so a single conditional
    // subtract is enough to wrap it.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] cand;
        sum      = '0;
        cand     = '0;
        o_valid  = 1'b0;
        o_winner = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            sum = {1'b0, i_ptr} + (PTR_W + 1)'(off);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
                sum = sum - (PTR_W + 1)'(NUM_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (i_req[cand]) begin
                o_valid  = 1'b1;
                o_winner = cand;
            end
        end
    end

endmodule

// File: rtl/bundle_arbiter.sv
// ---------------------------------------------------------------------------
// bundle_arbiter
//
// Round-robin write scheduler for a shared bit-vector register. One requester
// at a time owns the vector and may write single bits for a bounded burst.
// Between consecutive owners there is always exactly one idle cycle.
//
// Optional feature macro: BUNDLE_ARBITER_PARITY_EN
//   defined   -> parity output exists and equals ^vec (combinational)
//   undefined -> parity port and logic are absent
//
// Ports:
//   clock     in   1              rising-edge clock
//   reset_n   in   1              synchronous active-low reset
//   req       in   NUM_REQ        per-requester request / write-valid
//   last      in   NUM_REQ        per-requester final-beat marker
//   wr_index  in   NUM_REQ*IDX_W  packed bit indices, slice [i*IDX_W +: IDX_W]
//   wr_data   in   NUM_REQ        per-requester bit value
//   gnt       out  NUM_REQ        registered one-hot grant
//   busy      out  1              high while a requester owns the vector
//   owner     out  OWN_W          current or most recent owner
//   vec       out  WIDTH          shared vector, resets to all ones
//   parity    out  1              ^vec (only with BUNDLE_ARBITER_PARITY_EN)
// ---------------------------------------------------------------------------
module bundle_arbiter
    import bundle_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 4,
    parameter  int MAX_BURST = 4,
    localparam int IDX_W     = safe_clog2(WIDTH),
    localparam int OWN_W     = safe_clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       last,
    input  logic [NUM_REQ*IDX_W-1:0] wr_index,
    input  logic [NUM_REQ-1:0]       wr_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic [OWN_W-1:0]         owner,
    output logic [WIDTH-1:0]         vec
`ifdef BUNDLE_ARBITER_PARITY_EN
    ,
    output logic                     parity
`endif
);

    localparam int               CNT_W   = safe_clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MAX_BURST - 1);
    localparam logic [OWN_W-1:0] OWN_TOP = OWN_W'(NUM_REQ - 1);
    localparam logic [WIDTH-1:0] VEC_INIT = VEC_RESET[WIDTH-1:0];

    arb_state_e         r_state;
    arb_state_e         w_nextState;

    logic [OWN_W-1:0]   r_ptr;
    logic [OWN_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_beatCnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_busy;
    logic [WIDTH-1:0]   r_vec;

    logic [OWN_W-1:0]   w_ptrNext;
    logic [OWN_W-1:0]   w_ownerNext;
    logic [CNT_W-1:0]   w_beatCntNext;
    logic [NUM_REQ-1:0] w_gntNext;
    logic               w_busyNext;
    logic [WIDTH-1:0]   w_vecNext;

    logic               w_pickValid;
    logic [OWN_W-1:0]   w_pickWinner;
    logic               w_beat;
    logic               w_release;
    logic [IDX_W-1:0]   w_ownIndex;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (OWN_W)
    ) u_rrPick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_valid  (w_pickValid),
        .o_winner (w_pickWinner)
    );

    // Only the current owner's index slice is ever looked at.
    assign w_ownIndex = wr_index[r_owner*IDX_W +: IDX_W];

    // State register plus every registered datapath value. Reset wins over
    // everything, so a write arriving on the same edge as reset is lost.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_beatCnt <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_vec     <= VEC_INIT;
        end else begin
            r_state   <= w_nextState;
            r_ptr     <= w_ptrNext;
            r_owner   <= w_ownerNext;
            r_beatCnt <= w_beatCntNext;
            r_gnt     <= w_gntNext;
            r_busy    <= w_busyNext;
            r_vec     <= w_vecNext;
        end
    end

    // Next-state logic. A beat is the owner holding both its grant and its
    // request. Ownership ends when the owner withdraws its request, or on a
    // beat that is flagged last or that fills the burst budget; when both of
    // those coincide it is still one release.
    always_comb begin
        w_nextState = r_state;
        w_beat      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pickValid) begin
                    w_nextState = OWN;
                end
            end
            OWN: begin
                w_beat = r_gnt[r_owner] & req[r_owner];
                if (!req[r_owner] ||
                    (w_beat && (last[r_owner] || (r_beatCnt == CNT_TOP)))) begin
                    w_release   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and datapath. In IDLE the grant
    // is always dropped, which is what gives the one idle cycle between
    // owners. Out-of-range indices (only possible when WIDTH is not a power
    // of two) still consume a beat but leave the vector untouched.
    always_comb begin
        w_gntNext     = r_gnt;
        w_busyNext    = r_busy;
        w_ownerNext   = r_owner;
        w_ptrNext     = r_ptr;
        w_beatCntNext = r_beatCnt;
        w_vecNext     = r_vec;
        case (r_state)
            IDLE: begin
                w_gntNext  = '0;
                w_busyNext = 1'b0;
                if (w_pickValid) begin
                    w_ownerNext   = w_pickWinner;
                    w_gntNext     = NUM_REQ'(1) << w_pickWinner;
                    w_busyNext    = 1'b1;
                    w_beatCntNext = '0;
                end
            end
            OWN: begin
                if (w_beat) begin
                    if (int'(w_ownIndex) < WIDTH) begin
                        w_vecNext[w_ownIndex] = wr_data[r_owner];
                    end
                    w_beatCntNext = r_beatCnt + 1'b1;
                end
                if (w_release) begin
                    w_gntNext  = '0;
                    w_busyNext = 1'b0;
                    w_ptrNext  = (r_owner == OWN_TOP) ? '0 : r_owner + 1'b1;
                end
            end
            default: begin
                w_gntNext  = '0;
                w_busyNext = 1'b0;
            end
        endcase
    end

    assign gnt   = r_gnt;
    assign busy  = r_busy;
    assign owner = r_owner;
    assign vec   = r_vec;

`ifdef BUNDLE_ARBITER_PARITY_EN
    // Parity is a pure reduction of the stored vector, no extra latency.
    assign parity = ^r_vec;
`endif

endmodule

// File: tb/tb_bundle_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bundle_arbiter
//
// Self-checking bench for bundle_arbiter (NUM_REQ=4, WIDTH=4, MAX_BURST=4).
// A behavioural model tracks ownership, pointer and vector contents from the
// scheduling rules; one compare process checks the DUT against it on every
// falling edge. Directed sequences pin the model with literal expectations,
// then a long randomized run (with occasional resets) exercises the rest.
// ---------------------------------------------------------------------------
module tb_bundle_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 4;
    localparam int MAX_BURST = 4;
    localparam int IDX_W     = 2;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic [3:0] req      = '0;
    logic [3:0] last     = '0;
    logic [7:0] wr_index = '0;
    logic [3:0] wr_data  = '0;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic [3:0] vec;
`ifdef BUNDLE_ARBITER_PARITY_EN
    logic       parity;
`endif

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Behavioural model state
    bit         mBusy  = 1'b0;
    int         mOwner = 0;
    int         mPtr   = 0;
    int         mBeats = 0;
    logic [3:0] mVec   = 4'b1111;

    always #5 clock = ~clock;

    bundle_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .last     (last),
        .wr_index (wr_index),
        .wr_data  (wr_data),
        .gnt      (gnt),
        .busy     (busy),
        .owner    (owner),
        .vec      (vec)
`ifdef BUNDLE_ARBITER_PARITY_EN
        ,
        .parity   (parity)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, actual, expected);
        end
    endtask

    // Drive one cycle's worth of inputs, then wait to the following falling
    // edge so the rising edge in between has consumed them.
    task automatic applyStimulus(input logic rst, input logic [3:0] r,
                                 input logic [3:0] l, input logic [7:0] idx,
                                 input logic [3:0] d);
        reset_n  = rst;
        req      = r;
        last     = l;
        wr_index = idx;
        wr_data  = d;
        @(negedge clock);
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 4'b0, 4'b0, 8'h0, 4'b0);
        applyStimulus(1'b0, 4'b0, 4'b0, 8'h0, 4'b0);
    endtask

    function automatic logic [7:0] packIdx(input int who, input int ix);
        return 8'(ix << (who * IDX_W));
    endfunction

    // Reference model: grant goes to the first requester at or after the
    // pointer; the owner writes one bit per beat and gives up ownership on
    // last, on the MAX_BURST-th beat, or when it stops requesting.
    always @(posedge clock) begin
        int  c;
        int  idx;
        bit  found;
        bit  rel;
        found = 1'b0;
        rel   = 1'b0;
        if (!reset_n) begin
            mBusy  = 1'b0;
            mOwner = 0;
            mPtr   = 0;
            mBeats = 0;
            mVec   = 4'b1111;
        end else if (!mBusy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                c = (mPtr + k) % NUM_REQ;
                if (!found && req[c]) begin
                    found  = 1'b1;
                    mOwner = c;
                    mBusy  = 1'b1;
                    mBeats = 0;
                end
            end
        end else begin
            if (!req[mOwner]) begin
                rel = 1'b1;
            end else begin
                idx = (int'(wr_index) >> (mOwner * IDX_W)) % (1 << IDX_W);
                if (idx < WIDTH) mVec[idx] = wr_data[mOwner];
                mBeats++;
                if (last[mOwner] || mBeats == MAX_BURST) rel = 1'b1;
            end
            if (rel) begin
                mBusy = 1'b0;
                mPtr  = (mOwner + 1) % NUM_REQ;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("gnt", 32'(gnt), mBusy ? (32'd1 << mOwner) : 32'd0);
            checkOutput("busy", 32'(busy), 32'(mBusy));
            checkOutput("owner", 32'(owner), 32'(mOwner));
            checkOutput("vec", 32'(vec), 32'(mVec));
`ifdef BUNDLE_ARBITER_PARITY_EN
            checkOutput("parity", 32'(parity), 32'(^mVec));
`endif
        end
    end

    initial begin
        logic [3:0] expGnt [9];
        logic       rst;
        logic [3:0] r;
        logic [3:0] l;
        expGnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001};

        @(negedge clock);
        applyReset();
        checkEn = 1'b1;

        // Idle after reset
        repeat (5) applyStimulus(1'b1, 4'b0, 4'b0, 8'h0, 4'b0);
        checkOutput("idle_vec", 32'(vec), 32'h0000000f);
        checkOutput("idle_gnt", 32'(gnt), 32'h0);
        checkOutput("idle_busy", 32'(busy), 32'h0);
`ifdef BUNDLE_ARBITER_PARITY_EN
        checkOutput("idle_parity", 32'(parity), 32'h0);
`endif

        // Single-beat write by requester 1 to bit 2
        applyStimulus(1'b1, 4'b0010, 4'b0010, packIdx(1, 2), 4'b0000);
        checkOutput("single_gnt", 32'(gnt), 32'h2);
        checkOutput("single_vec_pre", 32'(vec), 32'hf);
        applyStimulus(1'b1, 4'b0010, 4'b0010, packIdx(1, 2), 4'b0000);
        checkOutput("single_vec", 32'(vec), 32'hb);
        checkOutput("single_gnt_rel", 32'(gnt), 32'h0);
        applyStimulus(1'b1, 4'b1111, 4'b1111, 8'h0, 4'b1111);
        checkOutput("ptr_after_1", 32'(owner), 32'h2);
        checkOutput("ptr_gnt", 32'(gnt), 32'h4);

        // Round-robin order with all requesting and single-beat bursts
        applyReset();
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, 4'b1111, 4'b1111, 8'($urandom), 4'b1111);
            checkOutput("rr_gnt", 32'(gnt), 32'(expGnt[k]));
        end

        // Maximum-length burst by requester 1 clearing every bit
        applyReset();
        applyStimulus(1'b1, 4'b0010, 4'b0, packIdx(1, 0), 4'b0);
        checkOutput("burst_gnt", 32'(gnt), 32'h2);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, 4'b0010, 4'b0, packIdx(1, b), 4'b0);
            if (b == 0) checkOutput("burst_vec1", 32'(vec), 32'he);
            if (b < 3) checkOutput("burst_hold", 32'(gnt), 32'h2);
        end
        checkOutput("burst_rel_gnt", 32'(gnt), 32'h0);
        checkOutput("burst_rel_busy", 32'(busy), 32'h0);
        checkOutput("burst_vec", 32'(vec), 32'h0);
`ifdef BUNDLE_ARBITER_PARITY_EN
        checkOutput("burst_parity", 32'(parity), 32'h0);
`endif
        applyStimulus(1'b1, 4'b0, 4'b0, 8'h0, 4'b0);

        // Reset arriving on the second beat of a burst by requester 2
        applyReset();
        applyStimulus(1'b1, 4'b0100, 4'b0, packIdx(2, 0), 4'b0);
        checkOutput("rst_owner", 32'(owner), 32'h2);
        applyStimulus(1'b1, 4'b0100, 4'b0, packIdx(2, 0), 4'b0);
        checkOutput("rst_beat1", 32'(vec), 32'he);
        applyStimulus(1'b0, 4'b0100, 4'b0, packIdx(2, 1), 4'b0);
        checkOutput("rst_vec", 32'(vec), 32'hf);
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_owner0", 32'(owner), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        applyStimulus(1'b1, 4'b0, 4'b0, 8'h0, 4'b0);

        // Non-owner requester 2 aims at bit 0 while owner 0 writes it
        applyReset();
        applyStimulus(1'b1, 4'b0001, 4'b0, 8'h0, 4'b0);
        repeat (2) begin
            applyStimulus(1'b1, 4'b0101, 4'b0, packIdx(0, 0) | packIdx(2, 0), 4'b0100);
            checkOutput("nonown_bit0", 32'(vec[0]), 32'h0);
            checkOutput("nonown_gnt", 32'(gnt), 32'h1);
        end
        applyStimulus(1'b1, 4'b0101, 4'b0001, 8'h0, 4'b0100);
        checkOutput("nonown_gap", 32'(gnt), 32'h0);
        applyStimulus(1'b1, 4'b0100, 4'b0, 8'h0, 4'b0100);
        checkOutput("nonown_next", 32'(gnt), 32'h4);
        checkOutput("nonown_owner", 32'(owner), 32'h2);
        applyStimulus(1'b1, 4'b0, 4'b0, 8'h0, 4'b0);

        // Randomized traffic with occasional resets
        repeat (3000) begin
            rst = ($urandom_range(0, 99) != 0);
            r   = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            l   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            applyStimulus(rst, r, l, 8'($urandom), 4'($urandom));
        end

        applyStimulus(1'b1, 4'b0, 4'b0, 8'h0, 4'b0);
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
